draw_rect_phys_ctl: RTL and testbench

Parametrised rectangle-position controller with gravity physics. It sits between the mouse decoder and the rectangle drawer in the image-control pipeline. The block tracks the mouse until a left click drops the rectangle. It then runs a fixed-point fall with optional damped bounce, settles on the floor, and can be re-grabbed by a further click.

---
 rtl/draw_rect_pkg.sv | 17 +
 rtl/draw_rect_phys_ctl_tick_gen.sv | 31 +++
 rtl/draw_rect_phys_ctl.sv | 137 +++++++++++++
 tb/tb_draw_rect_phys_ctl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/draw_rect_pkg.sv
// Shared types and default geometry for the rectangle-position controller.
package draw_rect_pkg;

  localparam int COORD_W = 12;

  localparam int DEF_VIS_WIDTH   = 800;
  localparam int DEF_VIS_HEIGHT  = 600;
  localparam int DEF_RECT_WIDTH  = 48;
  localparam int DEF_RECT_HEIGHT = 64;

  typedef enum logic [1:0] {
    FOLLOW,
    FALL,
    REST
  } state_t;

endpackage

// File: rtl/draw_rect_phys_ctl_tick_gen.sv
// Physics tick divider: counts while enabled, pulses tick for one cycle on the
// last count and wraps. A synchronous clear restarts the period.
module tick_gen #(
  parameter int TICK_DIV = 65000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/draw_rect_phys_ctl.sv
// Rectangle-position controller: follows the mouse, drops on click with
// fixed-point gravity, rests on the floor. Damped bounce: `DRAW_RECT_BOUNCE_EN.
module draw_rect_phys_ctl
  import draw_rect_pkg::*;
#(
  parameter int VIS_WIDTH   = DEF_VIS_WIDTH,
  parameter int VIS_HEIGHT  = DEF_VIS_HEIGHT,
  parameter int RECT_WIDTH  = DEF_RECT_WIDTH,
  parameter int RECT_HEIGHT = DEF_RECT_HEIGHT,
  parameter int FRAC_BITS   = 8,
  parameter int VEL_W       = 24,
  parameter int ACCEL       = 16,
  parameter int TICK_DIV    = 65000,
  parameter int MIN_BOUNCE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mouse_left,
  input  logic [COORD_W-1:0] mouse_x_position,
  input  logic [COORD_W-1:0] mouse_y_position,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic               falling,
  output logic               resting
);

  localparam logic [COORD_W-1:0]        FLOOR_C = COORD_W'(VIS_HEIGHT - RECT_HEIGHT);
  localparam logic [COORD_W-1:0]        XMAX_C  = COORD_W'(VIS_WIDTH - RECT_WIDTH);
  localparam logic signed [COORD_W:0]   FLOOR_S = (COORD_W + 1)'(VIS_HEIGHT - RECT_HEIGHT);
  localparam logic signed [VEL_W:0]     ACCEL_X = (VEL_W + 1)'(ACCEL);
  localparam logic signed [VEL_W-1:0]   VMAX    = {1'b0, {(VEL_W - 1){1'b1}}};
  localparam logic signed [VEL_W-1:0]   VMIN    = {1'b1, {(VEL_W - 1){1'b0}}};

  state_t                   state;
  logic                     left_q;
  logic signed [VEL_W-1:0]  v;

  logic                     click;
  logic                     tick;
  logic [COORD_W-1:0]       x_clamp;
  logic [COORD_W-1:0]       y_clamp;
  logic signed [COORD_W:0]  v_px;
  logic signed [COORD_W:0]  y_cand;
  logic signed [VEL_W:0]    v_sum;
  logic signed [VEL_W-1:0]  v_acc;

  assign click   = mouse_left & ~left_q;
  assign x_clamp = (mouse_x_position > XMAX_C)  ? XMAX_C  : mouse_x_position;
  assign y_clamp = (mouse_y_position > FLOOR_C) ? FLOOR_C : mouse_y_position;

  // Whole-pixel displacement is the floor of v, evaluated on a 13-bit signed grid.
  assign v_px   = (COORD_W + 1)'(v >>> FRAC_BITS);
  assign y_cand = $signed({1'b0, ypos}) + v_px;

  // Saturate instead of wrapping when the sign of the widened sum disagrees.
  assign v_sum = {v[VEL_W-1], v} + ACCEL_X;
  assign v_acc = (v_sum[VEL_W] != v_sum[VEL_W-1]) ? (v_sum[VEL_W] ? VMIN : VMAX)
                                                  : v_sum[VEL_W-1:0];

`ifdef DRAW_RECT_BOUNCE_EN
  localparam logic [VEL_W-1:0] MIN_B = VEL_W'(MIN_BOUNCE);

  logic signed [VEL_W-1:0] v_bnc;
  logic [VEL_W-1:0]        v_mag;
  logic                    settle;

  assign v_bnc  = -(v >>> 1);
  assign v_mag  = v_bnc[VEL_W-1] ? -v_bnc : v_bnc;
  assign settle = (v_mag >> FRAC_BITS) < MIN_B;
`endif

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state == FALL),
    .clr  (click),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FOLLOW;
      left_q  <= 1'b0;
      v       <= '0;
      xpos    <= '0;
      ypos    <= '0;
      falling <= 1'b0;
      resting <= 1'b0;
    end else begin
      left_q <= mouse_left;
      if (state == FOLLOW) begin
        xpos <= x_clamp;
        ypos <= y_clamp;
      end
      // A click outranks a coincident tick; that physics step is dropped.
      if (click) begin
        v       <= '0;
        resting <= 1'b0;
        if (state == FOLLOW) begin
          state   <= FALL;
          falling <= 1'b1;
        end else begin
          state   <= FOLLOW;
          falling <= 1'b0;
        end
      end else if ((state == FALL) && tick) begin
        if (y_cand >= FLOOR_S) begin
          ypos <= FLOOR_C;
`ifdef DRAW_RECT_BOUNCE_EN
          if (settle) begin
            v       <= '0;
            state   <= REST;
            falling <= 1'b0;
            resting <= 1'b1;
          end else begin
            v <= v_bnc;
          end
`else
          v       <= '0;
          state   <= REST;
          falling <= 1'b0;
          resting <= 1'b1;
`endif
        end else if (y_cand < 0) begin
          ypos <= '0;
          v    <= '0;
        end else begin
          ypos <= y_cand[COORD_W-1:0];
          v    <= v_acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_rect_phys_ctl.sv
// Self-checking bench for draw_rect_phys_ctl: per-cycle scoreboard fed by an
// integer reference model, plus directed checks of the drop/bounce/re-grab story.
module tb_draw_rect_phys_ctl;

  localparam int TD       = 4;
  localparam int FB       = 4;
  localparam int AC       = 16;
  localparam int FLOOR    = 600 - 64;
  localparam int XMAX     = 800 - 48;
  localparam int VMAX     = (1 << 23) - 1;
  localparam int MINB     = 1;
  localparam int M_FOLLOW = 0;
  localparam int M_FALL   = 1;
  localparam int M_REST   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_x_position = '0;
  logic [11:0] mouse_y_position = '0;
  logic [11:0] xpos, ypos, xpos_s, ypos_s;
  logic        falling, resting, falling_s, resting_s;

  int n_checks = 0;
  int n_fail   = 0;

  draw_rect_phys_ctl #(.TICK_DIV(TD), .FRAC_BITS(FB), .ACCEL(AC)) dut (
    .clk (clk), .rst (rst), .mouse_left (mouse_left),
    .mouse_x_position (mouse_x_position), .mouse_y_position (mouse_y_position),
    .xpos (xpos), .ypos (ypos), .falling (falling), .resting (resting)
  );

  draw_rect_phys_ctl #(.TICK_DIV(TD), .FRAC_BITS(FB), .ACCEL(AC), .MIN_BOUNCE(8)) dut_s (
    .clk (clk), .rst (rst), .mouse_left (mouse_left),
    .mouse_x_position (mouse_x_position), .mouse_y_position (mouse_y_position),
    .xpos (xpos_s), .ypos (ypos_s), .falling (falling_s), .resting (resting_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic over the behavioural rules.
  int  m_mode, m_x, m_y, m_v, m_cnt;
  bit  m_prev;
  bit  model_en = 1'b0;
  logic [25:0] exp_q[$];

  function automatic int fdiv(input int a, input int b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_mode = M_FOLLOW; m_x = 0; m_y = 0; m_v = 0; m_cnt = 0; m_prev = 1'b0;
  endtask

  task automatic model_step();
    bit click, tick;
    int yc, vn;
    click  = mouse_left && !m_prev;
    m_prev = mouse_left;
    tick   = (m_mode == M_FALL) && (m_cnt == TD - 1);
    if (m_mode == M_FOLLOW) begin
      m_x = imin(int'(mouse_x_position), XMAX);
      m_y = imin(int'(mouse_y_position), FLOOR);
    end
    if (click) begin
      m_v = 0; m_cnt = 0;
      m_mode = (m_mode == M_FOLLOW) ? M_FALL : M_FOLLOW;
    end else if (m_mode == M_FALL) begin
      m_cnt = (m_cnt + 1) % TD;
      if (tick) begin
        yc = m_y + fdiv(m_v, 1 << FB);
        if (yc >= FLOOR) begin
          m_y = FLOOR;
`ifdef DRAW_RECT_BOUNCE_EN
          vn = -fdiv(m_v, 2);
          if (fdiv((vn < 0) ? -vn : vn, 1 << FB) < MINB) begin
            m_v = 0; m_mode = M_REST;
          end else begin
            m_v = vn;
          end
`else
          vn = 0;
          m_v = vn; m_mode = M_REST;
`endif
        end else if (yc < 0) begin
          m_y = 0; m_v = 0;
        end else begin
          m_y = yc;
          m_v = imin(m_v + AC, VMAX);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    logic [11:0] ex, ey;
    if (model_en && !rst) begin
      model_step();
      ex = m_x[11:0];
      ey = m_y[11:0];
      exp_q.push_back({ex, ey, m_mode == M_FALL, m_mode == M_REST});
    end
  end

  always @(negedge clk) begin
    logic [25:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", {6'd0, xpos, ypos, falling, resting}, {6'd0, e});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int seq[9] = '{500, 501, 503, 506, 510, 515, 521, 528, 536};
    int waited;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_xpos", xpos, 0);    check("rst_ypos", ypos, 0);
    check("rst_falling", falling, 0); check("rst_resting", resting, 0);
    @(negedge clk);
    rst = 1'b0; model_reset(); model_en = 1'b1;
    cyc(2);
    check("post_rst_follow", falling, 0);

    // Follow and clamp.
    mouse_x_position = 12'd900; mouse_y_position = 12'd700;
    cyc(1);
    check("clamp_x", xpos, 752); check("clamp_y", ypos, 536);
    mouse_x_position = 12'd100; mouse_y_position = 12'd200;
    cyc(1);
    check("follow_x", xpos, 100); check("follow_y", ypos, 200);
    mouse_y_position = 12'd500;
    cyc(1);

    // Drop from y=500.
    mouse_left = 1'b1;
    cyc(1);
    check("drop_falling", falling, 1); check("drop_ypos", ypos, 500);
    mouse_left = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cyc(TD);
      check("drop_seq", ypos, seq[k]);
    end
    check("settle_resting", resting_s, 1); check("settle_ypos", ypos_s, 536);
`ifdef DRAW_RECT_BOUNCE_EN
    check("bounce_falling", falling, 1);
    cyc(TD);
    check("bounce_rise", ypos, 532);
    waited = 0;
    while (!resting && waited < 2000) begin
      cyc(1);
      waited++;
    end
    check("bounce_rest_reached", resting, 1);
    check("bounce_rest_ypos", ypos, 536);
`else
    check("floor_resting", resting, 1); check("floor_falling", falling, 0);
`endif

    // Re-grab from rest at (100,536).
    mouse_x_position = 12'd300; mouse_y_position = 12'd50; mouse_left = 1'b1;
    cyc(1);
    check("regrab_resting", resting, 0); check("regrab_falling", falling, 0);
    check("regrab_xfrozen", xpos, 100);
    mouse_left = 1'b0;
    cyc(1);
    check("regrab_x", xpos, 300); check("regrab_y", ypos, 50);

    // Click coinciding with the second tick of a fall.
    mouse_left = 1'b1;
    cyc(1);
    mouse_left = 1'b0;
    cyc(TD + 3);
    check("coinc_pre_y", ypos, 50);
    mouse_left = 1'b1; mouse_y_position = 12'd400;
    cyc(1);
    check("coinc_y_held", ypos, 50); check("coinc_follow", falling, 0);
    mouse_left = 1'b0;
    cyc(1);
    check("coinc_follow_y", ypos, 400);

    // Reset asserted mid-fall.
    mouse_left = 1'b1;
    cyc(1);
    mouse_left = 1'b0;
    cyc(10);
    model_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_xpos", xpos, 0);    check("midrst_ypos", ypos, 0);
    check("midrst_falling", falling, 0); check("midrst_resting", resting, 0);
    @(negedge clk);
    rst = 1'b0; model_reset(); model_en = 1'b1;
    cyc(3);
    check("midrst_stay_follow", falling, 0);

    // Randomized phase checked by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      mouse_x_position = 12'($urandom_range(0, 4095));
      mouse_y_position = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 59) == 0) mouse_left = ~mouse_left;
      cyc(1);
    end

    model_en = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
